// File: rtl/image_pixel_packer_if.sv
// Pixel stream produced by the image downscaler: a valid-qualified pixel with
// frame markers and no ready, so the consumer must never stall it.
interface image_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  clk;
    logic [DATA_WIDTH-1:0] payload;
    logic                  data_valid;
    logic                  sof;
    logic                  eof;

    modport sink   (input clk, payload, data_valid, sof, eof);
    modport source (input clk, output payload, data_valid, sof, eof);
endinterface

// File: rtl/image_pixel_packer.sv
// Packs PIXELS_PER_WORD pixels of an image_if stream into wide words and
// queues them in a show-ahead FIFO for a ready/valid sink.
module image_pixel_packer #(
    parameter int PIXEL_WIDTH     = 8,
    parameter int PIXELS_PER_WORD = 4,
    parameter int FIFO_DEPTH      = 16
) (
    image_if.sink                                     image_if_i,
    input  logic                                      rst_i,
    output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0]    m_data_o,
    output logic [PIXELS_PER_WORD-1:0]                m_keep_o,
    output logic                                      m_sof_o,
    output logic                                      m_eof_o,
    output logic                                      m_valid_o,
    input  logic                                      m_ready_i,
    output logic                                      overflow_o,
    output logic                                      framing_err_o,
    output logic [15:0]                               frame_cnt_o
);
    localparam int PW = PIXEL_WIDTH;
    localparam int N  = PIXELS_PER_WORD;
    localparam int LW = $clog2(N);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [N-1:0][PW-1:0] data;
        logic [N-1:0]         keep;
        logic                 sof;
        logic                 eof;
    } word_t;

    logic clk;
    assign clk = image_if_i.clk;

    // ---------------- pixel accumulator ----------------
    logic [LW-1:0]        lane_q, lane_d, eff_lane;
    logic [N-1:0][PW-1:0] acc_q, acc_d, merged;
    logic                 acc_sof_q, acc_sof_d;
    logic                 ferr_q, ferr_d;
    logic                 complete;
    word_t                push_word;

    always_comb begin
        // A sof always opens a fresh word; any partial word is abandoned.
        eff_lane = image_if_i.sof ? '0 : lane_q;
        merged   = image_if_i.sof ? '0 : acc_q;
        merged[eff_lane] = image_if_i.payload;

        push_word.data = merged;
        for (int i = 0; i < N; i++)
            push_word.keep[i] = (i <= int'(eff_lane));
        push_word.sof = image_if_i.sof | acc_sof_q;
        push_word.eof = image_if_i.eof;

        complete = image_if_i.data_valid &&
                   ((eff_lane == LW'(N-1)) || image_if_i.eof);

        lane_d    = lane_q;
        acc_d     = acc_q;
        acc_sof_d = acc_sof_q;
        ferr_d    = ferr_q;
        if (image_if_i.data_valid) begin
            if (image_if_i.sof && (lane_q != '0))
                ferr_d = 1'b1;
            if (complete) begin
                lane_d    = '0;
                acc_d     = '0;
                acc_sof_d = 1'b0;
            end else begin
                lane_d    = eff_lane + LW'(1);
                acc_d     = merged;
                acc_sof_d = push_word.sof;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            lane_q    <= '0;
            acc_q     <= '0;
            acc_sof_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            lane_q    <= lane_d;
            acc_q     <= acc_d;
            acc_sof_q <= acc_sof_d;
            ferr_q    <= ferr_d;
        end
    end

    // ---------------- output FIFO ----------------
    word_t         mem [FIFO_DEPTH];
    word_t         head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          full, pop, push_ok;

    assign head    = mem[rd_ptr_q];
    assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = m_valid_o & m_ready_i;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok = complete & (~full | pop);

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop)
            cnt_d = cnt_q + (AW+1)'(1);
        else if (pop && !push_ok)
            cnt_d = cnt_q - (AW+1)'(1);
        ovf_d  = ovf_q | (complete & ~push_ok);
        fcnt_d = (pop && head.eof) ? fcnt_q + 16'd1 : fcnt_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Head fields are forced to 0 while empty so reset leaves every output at 0.
    assign m_valid_o     = (cnt_q != '0);
    assign m_data_o      = m_valid_o ? head.data : '0;
    assign m_keep_o      = m_valid_o ? head.keep : '0;
    assign m_sof_o       = m_valid_o & head.sof;
    assign m_eof_o       = m_valid_o & head.eof;
    assign overflow_o    = ovf_q;
    assign framing_err_o = ferr_q;
    assign frame_cnt_o   = fcnt_q;

endmodule

// File: tb/tb_image_pixel_packer.sv
// Directed bench for image_pixel_packer: a queue-based word/FIFO model checked
// every cycle, plus literal expectations on the words the sink receives.
module tb_image_pixel_packer;
    logic        rst;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_sof, m_eof, m_valid, m_ready;
    logic        ovf, ferr;
    logic [15:0] fcnt;

    image_if #(.DATA_WIDTH(8)) img ();

    image_pixel_packer #(.PIXEL_WIDTH(8), .PIXELS_PER_WORD(4), .FIFO_DEPTH(16)) dut (
        .image_if_i    (img),
        .rst_i         (rst),
        .m_data_o      (m_data),
        .m_keep_o      (m_keep),
        .m_sof_o       (m_sof),
        .m_eof_o       (m_eof),
        .m_valid_o     (m_valid),
        .m_ready_i     (m_ready),
        .overflow_o    (ovf),
        .framing_err_o (ferr),
        .frame_cnt_o   (fcnt)
    );

    initial img.clk = 1'b0;
    always #5 img.clk = ~img.clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        s;
        logic        e;
    } mw_t;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    mw_t        mq[$];
    logic [7:0] pend[$];
    bit         pend_sof;
    bit         m_ovf, m_ferr;
    int         m_fcnt;
    mw_t        rx_log[$];

    always @(posedge img.clk) begin
        if (rst) begin
            mq.delete(); pend.delete();
            pend_sof = 0; m_ovf = 0; m_ferr = 0; m_fcnt = 0;
        end else begin
            bit  was_full, do_pop, do_push;
            mw_t w;
            was_full = (mq.size() == 16);
            do_pop   = (mq.size() != 0) && m_ready;
            do_push  = 0;
            if (do_pop) begin
                if (mq[0].e) m_fcnt = (m_fcnt + 1) % 65536;
                void'(mq.pop_front());
            end
            if (img.data_valid) begin
                if (img.sof) begin
                    if (pend.size() != 0) m_ferr = 1;
                    pend.delete();
                    pend_sof = 1;
                end
                pend.push_back(img.payload);
                if (img.eof || pend.size() == 4) begin
                    w.d = 0; w.k = 0;
                    for (int k = 0; k < pend.size(); k++) begin
                        w.d[8*k +: 8] = pend[k];
                        w.k[k] = 1'b1;
                    end
                    w.s = pend_sof; w.e = img.eof;
                    pend.delete(); pend_sof = 0;
                    do_push = 1;
                end
            end
            if (do_push) begin
                if (!was_full || do_pop) mq.push_back(w);
                else m_ovf = 1;
            end
        end
    end

    // Words actually handed to the sink, for literal checks.
    always @(posedge img.clk) begin
        if (!rst && m_valid && m_ready) begin
            mw_t r;
            r.d = m_data; r.k = m_keep; r.s = m_sof; r.e = m_eof;
            rx_log.push_back(r);
        end
    end

    always @(negedge img.clk) begin
        if (chk_en) begin
            chk("m_valid", m_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("m_data", m_data, mq[0].d);
                chk("m_keep", m_keep, mq[0].k);
                chk("m_sof",  m_sof,  mq[0].s);
                chk("m_eof",  m_eof,  mq[0].e);
            end
            chk("overflow",    ovf,  m_ovf);
            chk("framing_err", ferr, m_ferr);
            chk("frame_cnt",   fcnt, m_fcnt[15:0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic px(input logic [7:0] d, input logic s, input logic e);
        img.payload = d; img.sof = s; img.eof = e; img.data_valid = 1'b1;
        @(negedge img.clk);
        img.data_valid = 1'b0; img.sof = 1'b0; img.eof = 1'b0;
    endtask

    task automatic idle(input int n);
        img.data_valid = 1'b0;
        repeat (n) @(negedge img.clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge img.clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; m_ready = 1'b0;
        img.payload = '0; img.data_valid = 1'b0; img.sof = 1'b0; img.eof = 1'b0;
        repeat (2) @(negedge img.clk);
        chk("rst m_valid", m_valid, 0);
        chk("rst m_data",  m_data, 0);
        chk("rst flags",   {ovf, ferr}, 0);
        chk("rst fcnt",    fcnt, 0);
        rst = 1'b0;
        chk_en = 1;

        // 1: 8-pixel frame, sink always ready
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) px(8'(i + 1), i == 0, i == 7);
        idle(4);
        chk("t1 words", rx_log.size(), 2);
        if (rx_log.size() == 2) begin
            chk("t1 w0", {rx_log[0].d, rx_log[0].k, rx_log[0].s, rx_log[0].e}, {32'h04030201, 4'hF, 1'b1, 1'b0});
            chk("t1 w1", {rx_log[1].d, rx_log[1].k, rx_log[1].s, rx_log[1].e}, {32'h08070605, 4'hF, 1'b0, 1'b1});
        end
        chk("t1 fcnt", fcnt, 1);

        // 2: 6-pixel frame with random gaps
        rx_log.delete();
        for (int i = 0; i < 6; i++) begin
            px(8'(8'h11 + i), i == 0, i == 5);
            idle($urandom_range(0, 2));
        end
        idle(4);
        chk("t2 words", rx_log.size(), 2);
        if (rx_log.size() == 2) begin
            chk("t2 w0", {rx_log[0].d, rx_log[0].k, rx_log[0].s, rx_log[0].e}, {32'h14131211, 4'hF, 1'b1, 1'b0});
            chk("t2 w1", {rx_log[1].d, rx_log[1].k, rx_log[1].s, rx_log[1].e}, {32'h00001615, 4'h3, 1'b0, 1'b1});
        end
        chk("t2 fcnt", fcnt, 2);

        // 3: 20 words into a stalled sink
        do_reset();
        rx_log.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 80; i++) px(8'(i), i == 0, i == 79);
        idle(3);
        chk("t3 overflow", ovf, 1);
        chk("t3 occupancy", dut.cnt_q, 16);
        m_ready = 1'b1;
        begin
            int budget = 100;
            while (rx_log.size() < 16 && budget > 0) begin
                @(negedge img.clk);
                budget--;
            end
            if (budget == 0) chk("t3 drain timeout", rx_log.size(), 16);
        end
        idle(4);
        chk("t3 words", rx_log.size(), 16);
        if (rx_log.size() == 16) begin
            chk("t3 w0",  {rx_log[0].d, rx_log[0].s},  {32'h03020100, 1'b1});
            chk("t3 w15", {rx_log[15].d, rx_log[15].e}, {32'h3F3E3D3C, 1'b0});
        end
        chk("t3 fcnt", fcnt, 0);

        // 4: full FIFO, push and pop on the same edge
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 67; i++) px(8'(i), 1'b0, 1'b0);
        chk("t4 full", dut.cnt_q, 16);
        m_ready = 1'b1;
        px(8'd67, 1'b0, 1'b0);
        m_ready = 1'b0;
        chk("t4 overflow", ovf, 0);
        chk("t4 occupancy", dut.cnt_q, 16);

        // 5: sof lands after two pixels of a word
        do_reset();
        rx_log.delete();
        m_ready = 1'b1;
        px(8'hA1, 1'b1, 1'b0); px(8'hA2, 1'b0, 1'b0);
        px(8'hB1, 1'b1, 1'b0); px(8'hB2, 1'b0, 1'b0);
        px(8'hB3, 1'b0, 1'b0); px(8'hB4, 1'b0, 1'b1);
        idle(4);
        chk("t5 framing_err", ferr, 1);
        chk("t5 words", rx_log.size(), 1);
        if (rx_log.size() == 1)
            chk("t5 w0", {rx_log[0].d, rx_log[0].k, rx_log[0].s, rx_log[0].e}, {32'hB4B3B2B1, 4'hF, 1'b1, 1'b1});

        // 6: reset mid-frame with five words queued
        rx_log.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 22; i++) px(8'(8'h40 + i), i == 0, 1'b0);
        chk("t6 queued", dut.cnt_q, 5);
        do_reset();
        chk("t6 m_valid", m_valid, 0);
        chk("t6 flags", {ovf, ferr}, 0);
        chk("t6 fcnt", fcnt, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) px(8'(8'hC1 + i), i == 0, i == 3);
        idle(4);
        chk("t6 words", rx_log.size(), 1);
        if (rx_log.size() == 1)
            chk("t6 w0", {rx_log[0].d, rx_log[0].k, rx_log[0].s, rx_log[0].e}, {32'hC4C3C2C1, 4'hF, 1'b1, 1'b1});
        chk("t6 fcnt end", fcnt, 1);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
